// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/f_fetch_stage_if.sv
// Instruction memory request/grant/response bus between the fetch stage and imem.
interface f_fetch_stage_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/f_fetch_fifo.sv
// Two-entry registered instruction buffer between fetch and decode.
// Flush wins over push and pop; the head is read straight from storage.
module f_fetch_fifo
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_valid,
  output logic         o_full,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_wrPtr;
  logic         r_rdPtr;
  logic [1:0]   r_count;
  logic         w_doPush;
  logic         w_doPop;

  assign w_doPush = i_push && !i_flush;
  assign w_doPop  = i_pop && !i_flush && (r_count != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_doPush) r_wrPtr <= ~r_wrPtr;
      if (w_doPop)  r_rdPtr <= ~r_rdPtr;
      if (w_doPush && !w_doPop)      r_count <= r_count + 2'd1;
      else if (!w_doPush && w_doPop) r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_count = r_count;

  // The fetch FSM only requests when a slot is reserved, so this never fires.
  a_noOverflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_flush && !i_pop && (r_count == 2'd2)));

endmodule

// File: rtl/f_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch FSM, epoch-based
// discard of stale responses after redirects, and a 2-entry decode buffer.
module f_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  f_fetch_stage_if.master        imem,
  input  logic                   i_redirect,
  input  logic [XLEN-1:0]        i_redirect_pc,
  input  logic                   i_stallD,
  output logic                   o_validD,
  output logic [XLEN-1:0]        o_instrD,
  output logic [XLEN-1:0]        o_pcplus4D
);

  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_epoch;
  logic            r_tag;
  logic [XLEN-1:0] r_tagPc4;

  fetch_state_t    w_stateNext;
  logic [XLEN-1:0] w_pcNext;
  logic            w_epochNext;
  logic            w_tagNext;
  logic [XLEN-1:0] w_tagPc4Next;
  logic [XLEN-1:0] w_pcPlus4;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_occNext;
  logic            w_fifoValid;
  logic            w_fifoFull;
  logic [1:0]      w_count;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_pop     = w_fifoValid && !i_stallD && !i_redirect;
  assign w_wdata   = '{instr: imem.imem_rdata, pcplus4: r_tagPc4};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_epoch  <= 1'b0;
      r_tag    <= 1'b0;
      r_tagPc4 <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_pc     <= w_pcNext;
      r_epoch  <= w_epochNext;
      r_tag    <= w_tagNext;
      r_tagPc4 <= w_tagPc4Next;
    end
  end

  // Tagging with the pre-redirect epoch makes any in-flight response stale,
  // even across back-to-back redirects.
  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_epochNext  = r_epoch;
    w_tagNext    = r_tag;
    w_tagPc4Next = r_tagPc4;
    w_push       = 1'b0;
    w_occNext    = w_count;
    if (i_redirect) begin
      w_pcNext    = i_redirect_pc;
      w_epochNext = ~r_epoch;
    end
    case (r_state)
      S_IDLE: begin
        if (!i_redirect && !w_fifoFull) w_stateNext = S_REQ;
      end
      S_REQ: begin
        if (imem.imem_gnt) begin
          w_stateNext  = S_RSP;
          w_tagNext    = r_epoch;
          w_tagPc4Next = w_pcPlus4;
          if (!i_redirect) w_pcNext = w_pcPlus4;
        end else if (i_redirect) begin
          w_stateNext = S_IDLE;
        end
      end
      S_RSP: begin
        if (i_redirect) w_tagNext = r_epoch;
        if (imem.imem_rvalid) begin
          w_push = (r_tag == r_epoch) && !i_redirect;
          if (i_redirect) w_occNext = 2'd0;
          else            w_occNext = w_count + {1'b0, w_push} - {1'b0, w_pop};
          w_stateNext = (w_occNext < FULL_COUNT) ? S_REQ : S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  f_fetch_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_valid (w_fifoValid),
    .o_full  (w_fifoFull),
    .o_count (w_count)
  );

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = r_pc;

  assign o_validD   = w_fifoValid;
  assign o_instrD   = w_fifoValid ? w_head.instr   : INSTR_NOP;
  assign o_pcplus4D = w_fifoValid ? w_head.pcplus4 : '0;

endmodule
